// File: rtl/ex2_mult.sv
// ex2 benchmark datapath: sequential 4x4 unsigned shift-add multiplier with START/READY.
// State lives in fifteen separate flops S0..S14 so benches can observe and overwrite them.
module ex2_mult (
  input  logic CLK,
  input  logic RESET_N,
  input  logic START,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic CNTVCO2,
  output logic CNTVCON2,
  output logic READY,
  output logic P0,
  output logic P1,
  output logic P2,
  output logic P3,
  output logic P4,
  output logic P5,
  output logic P6,
  output logic P7
);

  logic S0, S1, S2, S3, S4, S5, S6, S7;
  logic S8, S9, S10, S11;
  logic S12, S13;
  logic S14;

  logic [7:0] pr;
  logic [3:0] m;
  logic [1:0] cnt;
  logic       busy;
  logic [7:0] pr_nxt;
  logic [3:0] m_nxt;
  logic [1:0] cnt_nxt;
  logic       busy_nxt;
  logic [4:0] sum;

  // One shift-add step: upper half of PR plus M when the current multiplier bit is set.
  function automatic logic [4:0] add_step(input logic [7:0] p, input logic [3:0] mc);
    return {1'b0, p[7:4]} + (p[0] ? {1'b0, mc} : 5'd0);
  endfunction

  assign pr   = {S7, S6, S5, S4, S3, S2, S1, S0};
  assign m    = {S11, S10, S9, S8};
  assign cnt  = {S13, S12};
  assign busy = S14;
  assign sum  = add_step(pr, m);

  always_comb begin
    pr_nxt   = pr;
    m_nxt    = m;
    cnt_nxt  = cnt;
    busy_nxt = busy;
    if (busy) begin
      pr_nxt   = {sum, pr[3:1]};
      cnt_nxt  = cnt + 2'd1;
      busy_nxt = (cnt != 2'd3);
    end else if (START) begin
      m_nxt    = {A3, A2, A1, A0};
      pr_nxt   = {4'b0000, B3, B2, B1, B0};
      cnt_nxt  = 2'd0;
      busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      {S14, S13, S12, S11, S10, S9, S8, S7, S6, S5, S4, S3, S2, S1, S0} <= 15'd0;
    else
      {S14, S13, S12, S11, S10, S9, S8, S7, S6, S5, S4, S3, S2, S1, S0} <=
        {busy_nxt, cnt_nxt, m_nxt, pr_nxt};
  end

  assign READY    = ~S14;
  assign CNTVCO2  = S14 & S13 & S12;
  assign CNTVCON2 = ~CNTVCO2;
  assign {P7, P6, P5, P4, P3, P2, P1, P0} = pr;

endmodule

// File: tb/tb_ex2_mult.sv
// Self-checking bench for ex2_mult: directed products, back-to-back starts, reset abort,
// forced-state stepping against an arithmetic reference, and X-freedom under random stimulus.
module tb_ex2_mult;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       cntvco2, cntvcon2, ready;
  logic [7:0] p_out;
  logic [14:0] fv;

  int errors = 0;
  int checks = 0;

  ex2_mult dut (
    .CLK(clk), .RESET_N(rst_n), .START(start),
    .A0(a_in[0]), .A1(a_in[1]), .A2(a_in[2]), .A3(a_in[3]),
    .B0(b_in[0]), .B1(b_in[1]), .B2(b_in[2]), .B3(b_in[3]),
    .CNTVCO2(cntvco2), .CNTVCON2(cntvcon2), .READY(ready),
    .P0(p_out[0]), .P1(p_out[1]), .P2(p_out[2]), .P3(p_out[3]),
    .P4(p_out[4]), .P5(p_out[5]), .P6(p_out[6]), .P7(p_out[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] st();
    return {dut.S14, dut.S13, dut.S12, dut.S11, dut.S10, dut.S9, dut.S8,
            dut.S7, dut.S6, dut.S5, dut.S4, dut.S3, dut.S2, dut.S1, dut.S0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic force_state();
    force dut.S0 = fv[0];   force dut.S1 = fv[1];   force dut.S2 = fv[2];
    force dut.S3 = fv[3];   force dut.S4 = fv[4];   force dut.S5 = fv[5];
    force dut.S6 = fv[6];   force dut.S7 = fv[7];   force dut.S8 = fv[8];
    force dut.S9 = fv[9];   force dut.S10 = fv[10]; force dut.S11 = fv[11];
    force dut.S12 = fv[12]; force dut.S13 = fv[13]; force dut.S14 = fv[14];
    #1;
    release dut.S0;  release dut.S1;  release dut.S2;  release dut.S3;  release dut.S4;
    release dut.S5;  release dut.S6;  release dut.S7;  release dut.S8;  release dut.S9;
    release dut.S10; release dut.S11; release dut.S12; release dut.S13; release dut.S14;
  endtask

  // Reference next state from the multiplier's rules, using whole-number arithmetic.
  function automatic logic [14:0] ref_next(input logic [14:0] s, input logic stt,
                                           input int a, input int b);
    int pr, m, cnt, bsy, sum;
    pr  = int'(s[7:0]);
    m   = int'(s[11:8]);
    cnt = int'(s[13:12]);
    bsy = int'(s[14]);
    if (bsy == 1) begin
      sum = (pr / 16) + ((pr % 2 == 1) ? m : 0);
      pr  = (sum * 8 + (pr / 2) % 8) % 256;
      bsy = (cnt == 3) ? 0 : 1;
      cnt = (cnt + 1) % 4;
    end else if (stt) begin
      m = a; pr = b; cnt = 0; bsy = 1;
    end
    return 15'(bsy * 16384 + cnt * 4096 + m * 256 + pr);
  endfunction

  // One product: START for one edge, optional START/operand noise while busy.
  task automatic run_mult(input int a, input int b, input bit noisy);
    @(negedge clk);
    a_in = 4'(a); b_in = 4'(b); start = 1'b1;
    @(posedge clk); #1;
    chk("start_ready_low", 32'(ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin a_in = 4'($urandom); b_in = 4'($urandom); end
      @(posedge clk); #1;
      if (i < 4) begin
        chk("busy_ready", 32'(ready), 32'd0);
        chk("cntvco2", 32'(cntvco2), (i == 3) ? 32'd1 : 32'd0);
      end else begin
        chk("done_ready", 32'(ready), 32'd1);
        chk("product", 32'(p_out), 32'(a * b));
        chk("cntvcon2", 32'(cntvcon2), 32'd1);
      end
    end
  endtask

  initial begin
    int aa[4] = '{3, 15, 9, 12};
    int bb[4] = '{5, 15, 6, 11};
    logic [14:0] exp_s;
    rst_n = 1'b0; start = 1'b0; a_in = 4'd0; b_in = 4'd0; fv = '0;

    // Reset state
    #12;
    chk("rst_p", 32'(p_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_cntvco2", 32'(cntvco2), 32'd0);
    chk("rst_cntvcon2", 32'(cntvcon2), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Directed products
    run_mult(3, 5, 1'b0);
    @(negedge clk); start = 1'b0; a_in = 4'd9; b_in = 4'd9;
    repeat (3) @(posedge clk);
    #1 chk("hold_p", 32'(p_out), 32'h0F);
    chk("hold_ready", 32'(ready), 32'd1);
    run_mult(15, 15, 1'b0);
    chk("max_p", 32'(p_out), 32'hE1);
    run_mult(0, 9, 1'b0);
    run_mult(7, 0, 1'b0);
    run_mult(11, 13, 1'b1);
    @(negedge clk); start = 1'b0;

    // Back-to-back with START held high
    @(negedge clk); a_in = 4'(aa[0]); b_in = 4'(bb[0]); start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 chk("b2b_start", 32'(ready), 32'd0);
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      chk("b2b_ready", 32'(ready), 32'd1);
      chk("b2b_p", 32'(p_out), 32'(aa[k] * bb[k]));
      @(negedge clk);
      if (k < 3) begin a_in = 4'(aa[k+1]); b_in = 4'(bb[k+1]); end
      else start = 1'b0;
    end

    // Reset mid-operation
    @(negedge clk); a_in = 4'd13; b_in = 4'd7; start = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0; a_in = 4'($urandom); b_in = 4'($urandom);
    #1;
    chk("abort_state", 32'(st()), 32'd0);
    chk("abort_p", 32'(p_out), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_cntvco2", 32'(cntvco2), 32'd0);
    chk("abort_cntvcon2", 32'(cntvcon2), 32'd1);
    @(negedge clk); rst_n = 1'b1; start = 1'b0;

    // Force all ones, step once
    @(negedge clk); fv = '1; force_state();
    chk("ones_cntvco2", 32'(cntvco2), 32'd1);
    exp_s = ref_next(15'h7FFF, 1'b0, 0, 0);
    @(posedge clk); #1;
    chk("ones_ready", 32'(ready), 32'd1);
    chk("ones_p", 32'(p_out), 32'(exp_s[7:0]));
    chk("ones_state", 32'(st()), 32'(exp_s));

    // Random forced states stepped against the reference
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'($urandom); a_in = 4'($urandom); b_in = 4'($urandom);
      fv = 15'($urandom);
      force_state();
      exp_s = ref_next(fv, start, int'(a_in), int'(b_in));
      @(posedge clk); #1 chk("forced_step", 32'(st()), 32'(exp_s));
    end
    @(negedge clk); start = 1'b0; fv = '0; force_state();

    // Random products with noisy START while busy
    for (int i = 0; i < 25; i++) begin
      run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
      @(negedge clk); start = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Random stimulus with periodic zero forcing: outputs never unknown
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'($urandom); a_in = 4'($urandom); b_in = 4'($urandom);
      if (i % 50 == 25) begin fv = '0; force_state(); end
      @(posedge clk); #1;
      chk("no_x", 32'($isunknown({p_out, ready, cntvco2, cntvcon2})), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
